ws28xx_word_decoder: RTL and testbench
======================================

// Module: ws28xx_word_decoder
// PURPOSE
//  Parametrised successor to the single-bit WS2811 decoder. Recovers WS28xx NRZ pulse-width data on masterClk,
//  deserialises it MSB-first into WORD_BITS-wide words with a one-cycle valid strobe, and tracks frame boundaries.
//  Flags glitches, over-long highs and truncated words. Sits between the satellite's serial input pin and the
//  per-channel register/shift logic, which consumes whole words instead of bit+clock pairs.
// PARAMETERS
//  WORD_BITS      24    bits per output word (1..32), MSB received first
//  CNT_W          16    width of pulse/low counters; all *_CYC values must fit
//  MIN_HIGH_CYC   5     high pulses shorter than this are glitches (100 ns @ 50 MHz)
//  T1H_THRES_CYC  23    high length > this decodes '1', else '0' (460 ns @ 50 MHz)
//  MAX_HIGH_CYC   50    high length >= this is an over-long error (1 us @ 50 MHz)
//  RESET_CYC      1250  continuous low >= this ends a frame (25 us @ 50 MHz)
// PORTS
//  masterClk   in   1          single clock; all logic on posedge
//  rst         in   1          synchronous, active-high reset
//  dataIn      in   1          asynchronous WS28xx line
//  wordOut     out  WORD_BITS  last completed word; held until the next word completes
//  wordValid   out  1          1-cycle pulse: wordOut updated this cycle
//  wordIndex   out  8          index of the word in wordOut within the current frame (0-based, saturates at 255)
//  frameActive out  1          high from first rising edge of a frame until frame end
//  frameEnd    out  1          1-cycle pulse at frame end (low for RESET_CYC)
//  errGlitch   out  1          1-cycle pulse: high pulse < MIN_HIGH_CYC, bit discarded
//  errLong     out  1          1-cycle pulse: high reached MAX_HIGH_CYC
//  errPartial  out  1          1-cycle pulse with frameEnd when 1..WORD_BITS-1 bits were left unassembled
// BEHAVIOUR
//  - dataIn passes a 2-FF synchroniser (flops reset to 0); edges are detected on the synchronised signal.
//  - Reset: all outputs 0, wordOut 0, counters 0, bit count 0, FSM in SYNC.
//  - FSM states: SYNC, IDLE, HIGH, LOW, ERR.
//    SYNC: wait for RESET_CYC consecutive low cycles, then IDLE. A line high at reset release is never decoded.
//    IDLE: on a rising edge go to HIGH, set frameActive, clear highCnt, bit count and wordIndex.
//    HIGH: highCnt increments each cycle. On a falling edge go to LOW and evaluate highCnt:
//      < MIN_HIGH_CYC -> errGlitch, no bit. Otherwise bit = (highCnt > T1H_THRES_CYC), shifted in.
//      If highCnt reaches MAX_HIGH_CYC while high: errLong, discard partial bits, go to ERR.
//    LOW: lowCnt increments each cycle. On a rising edge go to HIGH and clear highCnt.
//      At lowCnt == RESET_CYC: frameEnd, frameActive <= 0, errPartial if bit count != 0, discard bits, go to IDLE.
//    ERR: frameActive stays high. On low for RESET_CYC: frameEnd, frameActive <= 0, go to IDLE.
//      A rising edge in ERR resets lowCnt only; no decoding until the frame ends.
//  - Word assembly: when the WORD_BITS-th bit is accepted, wordOut <= {shift, bit}, wordValid pulses, bit count <= 0.
//    wordIndex = number of words already completed in this frame (0 for the first word); it then increments,
//    saturating at 255.
//  - Latency: wordValid/error pulses occur 3 masterClk cycles after the dataIn falling edge (2 sync + 1 register).
//    frameEnd occurs RESET_CYC+3 cycles after the last falling edge.
//  - Counters saturate at all-ones; no wrap-around. A low period of exactly RESET_CYC-1 does not end the frame.
//  - Simultaneous events: errPartial, when asserted, is always coincident with frameEnd. wordValid and errGlitch
//    are mutually exclusive.
//  - rst mid-frame: immediate return to SYNC. No frameEnd and no wordValid are emitted for the aborted frame.
// TESTING (masterClk 50 MHz, default parameters)
//  1. rst, line low 1300 cyc; send 24 bits 0xA5C3F0 (1 = 30H/15L cyc, 0 = 15H/30L) -> one wordValid,
//     wordOut = 0xA5C3F0, wordIndex = 0.
//  2. Two words 0x123456, 0xABCDEF, then low 1300 cyc -> wordValid x2 (wordIndex 0, 1); frameEnd once;
//     frameActive falls with frameEnd.
//  3. 3-cyc high glitch between bits 5 and 6 of 0xFFFFFF -> errGlitch once; word still 0xFFFFFF.
//  4. 60-cyc high mid-word -> errLong at cycle 50 of the high; no wordValid; frameEnd after 1250 low cyc.
//  5. 10 bits then 1300 low -> frameEnd and errPartial in the same cycle; no wordValid. Then a low gap of
//     1249 cyc mid-word -> no frameEnd.
//  6. dataIn high during rst release -> nothing decoded until 1250 low cyc. rst mid-word -> all outputs 0,
//     next full frame decodes correctly.

Source files
------------

// File: rtl/ws28xx_word_decoder_if.sv
// Word-level handshake between the WS28xx line decoder and its consumer.
// The decoder takes the slave view; the serial source / consumer takes the master view.
interface ws28xx_word_decoder_if #(
  parameter int unsigned WORD_BITS = 24
);
  logic                 dataIn;
  logic [WORD_BITS-1:0] wordOut;
  logic                 wordValid;
  logic [7:0]           wordIndex;
  logic                 frameActive;
  logic                 frameEnd;
  logic                 errGlitch;
  logic                 errLong;
  logic                 errPartial;

  modport master (
    output dataIn,
    input  wordOut,
    input  wordValid,
    input  wordIndex,
    input  frameActive,
    input  frameEnd,
    input  errGlitch,
    input  errLong,
    input  errPartial
  );

  modport slave (
    input  dataIn,
    output wordOut,
    output wordValid,
    output wordIndex,
    output frameActive,
    output frameEnd,
    output errGlitch,
    output errLong,
    output errPartial
  );
endinterface

// File: rtl/ws28xx_word_decoder.sv
// WS28xx NRZ pulse-width decoder: recovers bits from high-pulse length, packs them MSB-first
// into words and tracks frame boundaries, reporting glitches, over-long highs and short words.
module ws28xx_word_decoder #(
  parameter int unsigned WORD_BITS     = 24,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_HIGH_CYC  = 5,
  parameter int unsigned T1H_THRES_CYC = 23,
  parameter int unsigned MAX_HIGH_CYC  = 50,
  parameter int unsigned RESET_CYC     = 1250
) (
  input  logic                    masterClk,
  input  logic                    rst,
  ws28xx_word_decoder_if.slave    bus
);

  localparam int unsigned BitCntW = $clog2(WORD_BITS + 1);

  typedef enum logic [2:0] {StSync, StIdle, StHigh, StLow, StErr} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]     high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]     low_cnt_q, low_cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [7:0]           word_index_q, word_index_d;
  logic [7:0]           words_done_q, words_done_d;
  logic                 word_valid_q, word_valid_d;
  logic                 frame_active_q, frame_active_d;
  logic                 frame_end_q, frame_end_d;
  logic                 err_glitch_q, err_glitch_d;
  logic                 err_long_q, err_long_d;
  logic                 err_partial_q, err_partial_d;

  logic                 rise, fall;
  logic [CNT_W:0]       high_len, low_len;
  logic                 bit_val;
  logic [WORD_BITS-1:0] shift_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // Lengths include the current cycle, so they equal the pulse length seen on the line.
  assign high_len   = {1'b0, high_cnt_q} + (CNT_W + 1)'(1);
  assign low_len    = {1'b0, low_cnt_q} + (CNT_W + 1)'(1);
  assign bit_val    = high_len > (CNT_W + 1)'(T1H_THRES_CYC);
  assign shift_next = WORD_BITS'({shift_q, bit_val});

  always_comb begin
    state_d        = state_q;
    high_cnt_d     = high_cnt_q;
    low_cnt_d      = low_cnt_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    word_d         = word_q;
    word_index_d   = word_index_q;
    words_done_d   = words_done_q;
    frame_active_d = frame_active_q;
    word_valid_d   = 1'b0;
    frame_end_d    = 1'b0;
    err_glitch_d   = 1'b0;
    err_long_d     = 1'b0;
    err_partial_d  = 1'b0;

    unique case (state_q)
      StSync: begin
        if (sync2_q) begin
          low_cnt_d = '0;
        end else if (low_len == (CNT_W + 1)'(RESET_CYC)) begin
          low_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          low_cnt_d = sat_inc(low_cnt_q);
        end
      end

      StIdle: begin
        if (rise) begin
          state_d        = StHigh;
          frame_active_d = 1'b1;
          high_cnt_d     = '0;
          bit_cnt_d      = '0;
          shift_d        = '0;
          word_index_d   = '0;
          words_done_d   = '0;
        end
      end

      StHigh: begin
        if (high_len >= (CNT_W + 1)'(MAX_HIGH_CYC)) begin
          err_long_d = 1'b1;
          bit_cnt_d  = '0;
          shift_d    = '0;
          low_cnt_d  = '0;
          state_d    = StErr;
        end else if (fall) begin
          state_d   = StLow;
          low_cnt_d = '0;
          if (high_len < (CNT_W + 1)'(MIN_HIGH_CYC)) begin
            err_glitch_d = 1'b1;
          end else if (bit_cnt_q == BitCntW'(WORD_BITS - 1)) begin
            word_d       = shift_next;
            word_valid_d = 1'b1;
            shift_d      = '0;
            bit_cnt_d    = '0;
            word_index_d = words_done_q;
            words_done_d = (&words_done_q) ? words_done_q : words_done_q + 8'd1;
          end else begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end else begin
          high_cnt_d = sat_inc(high_cnt_q);
        end
      end

      StLow: begin
        if (low_len == (CNT_W + 1)'(RESET_CYC)) begin
          frame_end_d    = 1'b1;
          err_partial_d  = (bit_cnt_q != '0);
          frame_active_d = 1'b0;
          bit_cnt_d      = '0;
          shift_d        = '0;
          state_d        = StIdle;
          // A rise landing on the boundary cycle already belongs to the next frame.
          if (rise) begin
            state_d        = StHigh;
            frame_active_d = 1'b1;
            high_cnt_d     = '0;
            word_index_d   = '0;
            words_done_d   = '0;
          end
        end else if (rise) begin
          state_d    = StHigh;
          high_cnt_d = '0;
        end else begin
          low_cnt_d = sat_inc(low_cnt_q);
        end
      end

      StErr: begin
        if (sync2_q) begin
          low_cnt_d = '0;
        end else if (low_len == (CNT_W + 1)'(RESET_CYC)) begin
          frame_end_d    = 1'b1;
          frame_active_d = 1'b0;
          low_cnt_d      = '0;
          state_d        = StIdle;
        end else begin
          low_cnt_d = sat_inc(low_cnt_q);
        end
      end

      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge masterClk) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      state_q        <= StSync;
      high_cnt_q     <= '0;
      low_cnt_q      <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      word_q         <= '0;
      word_index_q   <= '0;
      words_done_q   <= '0;
      word_valid_q   <= 1'b0;
      frame_active_q <= 1'b0;
      frame_end_q    <= 1'b0;
      err_glitch_q   <= 1'b0;
      err_long_q     <= 1'b0;
      err_partial_q  <= 1'b0;
    end else begin
      sync1_q        <= bus.dataIn;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      state_q        <= state_d;
      high_cnt_q     <= high_cnt_d;
      low_cnt_q      <= low_cnt_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      word_q         <= word_d;
      word_index_q   <= word_index_d;
      words_done_q   <= words_done_d;
      word_valid_q   <= word_valid_d;
      frame_active_q <= frame_active_d;
      frame_end_q    <= frame_end_d;
      err_glitch_q   <= err_glitch_d;
      err_long_q     <= err_long_d;
      err_partial_q  <= err_partial_d;
    end
  end

  assign bus.wordOut     = word_q;
  assign bus.wordValid   = word_valid_q;
  assign bus.wordIndex   = word_index_q;
  assign bus.frameActive = frame_active_q;
  assign bus.frameEnd    = frame_end_q;
  assign bus.errGlitch   = err_glitch_q;
  assign bus.errLong     = err_long_q;
  assign bus.errPartial  = err_partial_q;

endmodule

// File: tb/tb_ws28xx_word_decoder.sv
// Directed bench for ws28xx_word_decoder: drives pulse-width waveforms on negedge and checks
// event counts, captured words and latencies with immediate assertions.
module tb_ws28xx_word_decoder;
  localparam int unsigned WB = 24;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  ws28xx_word_decoder_if #(.WORD_BITS(WB)) bus ();

  ws28xx_word_decoder #(.WORD_BITS(WB)) dut (
    .masterClk (clk),
    .rst       (rst),
    .bus       (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_fend = 0, n_glitch = 0, n_long = 0, n_part = 0;
  int n_part_alone = 0, n_clash = 0;
  int valid_cyc = 0, fend_cyc = 0, long_cyc = 0;
  logic fa_at_fend = 1'b0;
  logic [WB-1:0] words [16];
  logic [7:0]    idxs  [16];

  always @(negedge clk) begin
    if (bus.wordValid) begin
      words[n_valid % 16] <= bus.wordOut;
      idxs[n_valid % 16]  <= bus.wordIndex;
      n_valid             <= n_valid + 1;
      valid_cyc           <= cyc;
    end
    if (bus.frameEnd) begin
      n_fend     <= n_fend + 1;
      fend_cyc   <= cyc;
      fa_at_fend <= bus.frameActive;
    end
    if (bus.errGlitch) n_glitch <= n_glitch + 1;
    if (bus.errLong) begin
      n_long   <= n_long + 1;
      long_cyc <= cyc;
    end
    if (bus.errPartial) n_part <= n_part + 1;
    if (bus.errPartial && !bus.frameEnd) n_part_alone <= n_part_alone + 1;
    if (bus.wordValid && bus.errGlitch) n_clash <= n_clash + 1;
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int b_valid, b_fend, b_glitch, b_long, b_part;
  int fall_cyc = 0, rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_valid  = n_valid;
    b_fend   = n_fend;
    b_glitch = n_glitch;
    b_long   = n_long;
    b_part   = n_part;
  endtask

  task automatic send_bit(input logic b);
    bus.dataIn = 1'b1;
    tick(b ? 30 : 15);
    bus.dataIn = 1'b0;
    fall_cyc   = cyc;
    tick(b ? 15 : 30);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    rst        = 1'b1;
    bus.dataIn = 1'b0;
    tick(4);
    check("reset_word", {8'h0, bus.wordOut}, 32'h0);
    check("reset_flags", {24'h0, bus.wordIndex},
          32'h0);
    check("reset_pulses", {26'h0, bus.wordValid, bus.frameActive, bus.frameEnd, bus.errGlitch,
                           bus.errLong, bus.errPartial}, 32'h0);
    rst = 1'b0;
    tick(1300);

    // 1: single word, latency from last falling edge
    snap();
    send_bits(32'hA5C3F0, 24);
    check("t1_nvalid", n_valid - b_valid, 1);
    check("t1_word", {8'h0, words[b_valid % 16]}, 32'hA5C3F0);
    check("t1_index", {24'h0, idxs[b_valid % 16]}, 0);
    check("t1_latency", valid_cyc - fall_cyc, 3);
    check("t1_active", {31'h0, bus.frameActive}, 1);
    tick(1300);
    check("t1_fend", n_fend - b_fend, 1);

    // 2: two words in one frame, then frame end
    snap();
    send_bits(32'h123456, 24);
    send_bits(32'hABCDEF, 24);
    tick(1300);
    check("t2_nvalid", n_valid - b_valid, 2);
    check("t2_word0", {8'h0, words[b_valid % 16]}, 32'h123456);
    check("t2_idx0", {24'h0, idxs[b_valid % 16]}, 0);
    check("t2_word1", {8'h0, words[(b_valid + 1) % 16]}, 32'hABCDEF);
    check("t2_idx1", {24'h0, idxs[(b_valid + 1) % 16]}, 1);
    check("t2_nfend", n_fend - b_fend, 1);
    check("t2_fend_latency", fend_cyc - fall_cyc, 1253);
    check("t2_active_at_fend", {31'h0, fa_at_fend}, 0);
    check("t2_active_after", {31'h0, bus.frameActive}, 0);

    // 3: 3-cycle glitch between bits 5 and 6
    snap();
    send_bits(32'h3F, 6);
    bus.dataIn = 1'b1;
    tick(3);
    bus.dataIn = 1'b0;
    tick(15);
    send_bits(32'h3FFFF, 18);
    tick(1300);
    check("t3_nglitch", n_glitch - b_glitch, 1);
    check("t3_nvalid", n_valid - b_valid, 1);
    check("t3_word", {8'h0, words[b_valid % 16]}, 32'hFFFFFF);
    check("t3_clash", n_clash, 0);

    // 4: 60-cycle high mid-word
    snap();
    send_bits(32'h2B5, 10);
    bus.dataIn = 1'b1;
    rise_cyc   = cyc;
    tick(60);
    bus.dataIn = 1'b0;
    tick(1300);
    check("t4_nlong", n_long - b_long, 1);
    check("t4_long_latency", long_cyc - rise_cyc, 53);
    check("t4_nvalid", n_valid - b_valid, 0);
    check("t4_nfend", n_fend - b_fend, 1);
    check("t4_npart", n_part - b_part, 0);

    // 5: truncated word, then a 1249-cycle gap that must not end the frame
    snap();
    send_bits(32'h3A1, 10);
    tick(1300);
    check("t5_nfend", n_fend - b_fend, 1);
    check("t5_npart", n_part - b_part, 1);
    check("t5_part_alone", n_part_alone, 0);
    check("t5_nvalid", n_valid - b_valid, 0);
    snap();
    send_bits(32'hABC, 12);
    bus.dataIn = 1'b1;
    tick(30);
    bus.dataIn = 1'b0;
    tick(1249);
    send_bits(32'h5A5, 11);
    check("t5_gap_nfend", n_fend - b_fend, 0);
    check("t5_gap_nvalid", n_valid - b_valid, 1);
    check("t5_gap_word", {8'h0, words[b_valid % 16]}, 32'hABCDA5);
    tick(1300);

    // 6: line high at reset release, then reset mid-word
    rst        = 1'b1;
    bus.dataIn = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(100);
    snap();
    send_bits(32'h5AA55A, 24);
    tick(40);
    check("t6_sync_nvalid", n_valid - b_valid, 0);
    check("t6_sync_active", {31'h0, bus.frameActive}, 0);
    tick(1300);
    send_bits(32'h155, 10);
    check("t6_pre_rst_active", {31'h0, bus.frameActive}, 1);
    rst        = 1'b1;
    bus.dataIn = 1'b0;
    snap();
    tick(1);
    check("t6_rst_outputs", {bus.wordOut, bus.wordValid, bus.frameActive, bus.frameEnd,
                             bus.errGlitch, bus.errLong, bus.errPartial}, 32'h0);
    check("t6_rst_index", {24'h0, bus.wordIndex}, 0);
    tick(2);
    rst = 1'b0;
    tick(1300);
    check("t6_abort_nfend", n_fend - b_fend, 0);
    check("t6_abort_nvalid", n_valid - b_valid, 0);
    snap();
    send_bits(32'h5AA55A, 24);
    tick(1300);
    check("t6_nvalid", n_valid - b_valid, 1);
    check("t6_word", {8'h0, words[b_valid % 16]}, 32'h5AA55A);
    check("t6_index", {24'h0, idxs[b_valid % 16]}, 0);
    check("t6_nfend", n_fend - b_fend, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
